// File: rtl/blink_axil_regs.sv
// blink_axil_regs: AXI4-Lite slave with four R/W registers, a read-only
// STATUS register and an LED blink engine driven from those registers.
// Optional feature macro: BLINK_IRQ_EN (adds irq output and IRQ_STATUS at 0x14).
module blink_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int LED_WIDTH          = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            led
`ifdef BLINK_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  // Word index (byte address bits [4:2]) of each register
  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_HALF    = 3'd1;
  localparam logic [2:0] IDX_MASK    = 3'd2;
  localparam logic [2:0] IDX_SCRATCH = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;
`ifdef BLINK_IRQ_EN
  localparam logic [2:0] IDX_IRQ     = 3'd5;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel state
  logic          aw_full_q, aw_full_d;
  logic [2:0]    aw_idx_q, aw_idx_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;

  // Read channel state
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  // Register file and blink engine state
  logic [DW-1:0]        ctrl_q, ctrl_d;
  logic [DW-1:0]        half_q, half_d;
  logic [DW-1:0]        mask_q, mask_d;
  logic [DW-1:0]        scratch_q, scratch_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 led_state_q, led_state_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
`ifdef BLINK_IRQ_EN
  logic                 irq_status_q, irq_status_d;
  logic                 irq_q, irq_d;
`endif

  // Decode helpers
  logic          commit;
  logic          wr_ok;
  logic          wr_hit;
  logic [DW-1:0] wmask;
  logic [2:0]    ar_idx;
  logic [DW-1:0] rd_val;
  logic          rd_ok;
  logic          run;
  logic          toggle;

  // Both halves of a write are latched: the register update happens now
  assign commit = aw_full_q & w_full_q;
  assign wr_hit = commit & wr_ok;
  assign ar_idx = S_AXI_ARADDR[4:2];

  // Expand WSTRB into a per-bit write mask, one byte lane at a time
  for (genvar gi = 0; gi < NB; gi++) begin : g_strb
    assign wmask[gi*8 +: 8] = {8{wstrb_q[gi]}};
  end

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [DW-1:0] m);
    merge_bytes = (old_v & ~m) | (new_v & m);
  endfunction

  // Decide whether the latched write address maps to a writable register
  always_comb begin
    wr_ok = 1'b0;
    case (aw_idx_q)
      IDX_CTRL, IDX_HALF, IDX_MASK, IDX_SCRATCH: wr_ok = 1'b1;
`ifdef BLINK_IRQ_EN
      IDX_IRQ: wr_ok = 1'b1;
`endif
      default: wr_ok = 1'b0;
    endcase
  end

  // Write channel: independent AW/W latches, commit, then hold B until BREADY
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (S_AXI_AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[4:2];
    end
    if (S_AXI_WVALID && wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    // Ready flags are registered copies of the next-cycle acceptance condition
    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  // Register file update on a successful commit; SLVERR leaves everything alone
  always_comb begin
    ctrl_d    = ctrl_q;
    half_d    = half_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    if (wr_hit) begin
      case (aw_idx_q)
        IDX_CTRL:    ctrl_d    = merge_bytes(ctrl_q, wdata_q, wmask);
        IDX_HALF:    half_d    = merge_bytes(half_q, wdata_q, wmask);
        IDX_MASK:    mask_d    = merge_bytes(mask_q, wdata_q, wmask);
        IDX_SCRATCH: scratch_d = merge_bytes(scratch_q, wdata_q, wmask);
        default:     ctrl_d    = ctrl_q;
      endcase
    end
  end

  // Blink engine: half-period counter, LED state toggle and registered led
  always_comb begin
    run         = ctrl_q[0] && (half_q != '0);
    toggle      = 1'b0;
    cnt_d       = cnt_q;
    led_state_d = led_state_q;
    if (wr_hit && (aw_idx_q == IDX_CTRL || aw_idx_q == IDX_HALF)) begin
      // Reprogramming restarts the half-period from zero
      cnt_d = '0;
    end else if (!run) begin
      cnt_d       = '0;
      led_state_d = 1'b0;
    end else if (cnt_q == half_q - 32'd1) begin
      cnt_d       = '0;
      led_state_d = !led_state_q;
      toggle      = 1'b1;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    led_d = (led_state_q ^ ctrl_q[1]) ? mask_q[LED_WIDTH-1:0] : '0;
  end

`ifdef BLINK_IRQ_EN
  // Sticky toggle flag with write-one-to-clear; a toggle wins over a clear
  always_comb begin
    irq_status_d = irq_status_q;
    if (wr_hit && aw_idx_q == IDX_IRQ && wstrb_q[0] && wdata_q[0]) begin
      irq_status_d = 1'b0;
    end
    if (toggle) begin
      irq_status_d = 1'b1;
    end
    irq_d = irq_status_q & ctrl_q[2];
  end
`endif

  // Read mux: current register values, SLVERR with zero data when unmapped
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (ar_idx)
      IDX_CTRL:    rd_val = ctrl_q;
      IDX_HALF:    rd_val = half_q;
      IDX_MASK:    rd_val = mask_q;
      IDX_SCRATCH: rd_val = scratch_q;
      IDX_STATUS:  rd_val = {cnt_q[23:0], 7'd0, led_state_q};
`ifdef BLINK_IRQ_EN
      IDX_IRQ:     rd_val = {{(DW-1){1'b0}}, irq_status_q};
`endif
      default:     rd_ok  = 1'b0;
    endcase
  end

  // Read channel: capture on AR handshake, hold R until RREADY
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (S_AXI_ARVALID && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_val : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    arready_d = !rvalid_d;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_full_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      ctrl_q       <= '0;
      half_q       <= '0;
      mask_q       <= '0;
      scratch_q    <= '0;
      cnt_q        <= '0;
      led_state_q  <= 1'b0;
      led_q        <= '0;
`ifdef BLINK_IRQ_EN
      irq_status_q <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      ctrl_q       <= ctrl_d;
      half_q       <= half_d;
      mask_q       <= mask_d;
      scratch_q    <= scratch_d;
      cnt_q        <= cnt_d;
      led_state_q  <= led_state_d;
      led_q        <= led_d;
`ifdef BLINK_IRQ_EN
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign led           = led_q;
`ifdef BLINK_IRQ_EN
  assign irq           = irq_q;
`endif

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_bits;
`ifdef BLINK_IRQ_EN
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
`else
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, toggle};
`endif

endmodule

// File: tb/tb_blink_axil_regs.sv
// tb_blink_axil_regs: scoreboard-driven bench for blink_axil_regs.
module tb_blink_axil_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  led;
`ifdef BLINK_IRQ_EN
  logic        irq;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Scoreboards: expected write responses and expected {rresp, rdata}
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [3:0]  exp_led[$];

  always #5 clk = ~clk;

  blink_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .LED_WIDTH(4)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .led(led)
`ifdef BLINK_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus driver: AW and W together, returns once BVALID is seen
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bit aw_done, w_done, hs_aw, hs_w;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(); n++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 50) begin tick(); n++; end
    resp = bresp;
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr=%h: got bvalid=0 want 1", addr);
    end
  endtask

  // Bus driver: AR then wait for RVALID; R handshake completes if rready=1
  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    bit done, hs;
    araddr = addr; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      hs = arready;
      tick(); n++;
      if (hs) done = 1'b1;
    end
    arvalid = 1'b0;
    while (!rvalid && n < 50) begin tick(); n++; end
    data = rdata; resp = rresp;
    if (!rvalid) begin
      vectors++; miscompares++;
      $display("FAIL read_timeout addr=%h: got rvalid=0 want 1", addr);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, 4'hF, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_hs: got %b want 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp});
    end
    vectors++;
    if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    vectors++;
    if (led !== 4'd0) begin miscompares++; $display("FAIL reset_led: got %h want 0", led); end
    rst = 1'b0;
    tick();
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_regs();
    logic [1:0] resp, eb;
    logic [31:0] data;
    logic [33:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back(OKAY);
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      eb = exp_b.pop_front(); vectors++;
      if (resp !== eb) begin miscompares++; $display("FAIL regs_bresp[%0d]: got %b want %b", i, resp, eb); end
    end
    for (int i = 0; i < 4; i++) begin
      exp_r.push_back({OKAY, 32'(i + 1)});
      axi_read(5'(i * 4), data, resp);
      e = exp_r.pop_front(); vectors++;
      if ({resp, data} !== e) begin miscompares++; $display("FAIL regs_read[%0d]: got %h want %h", i, {resp, data}, e); end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, eb;
    logic [31:0] data;
    logic [33:0] e;
    exp_b.push_back(OKAY);
    axi_write(5'h0C, 32'hAABBCCDD, 4'hF, resp);
    eb = exp_b.pop_front(); vectors++;
    if (resp !== eb) begin miscompares++; $display("FAIL strobe_bresp0: got %b want %b", resp, eb); end
    exp_b.push_back(OKAY);
    axi_write(5'h0C, 32'h11223344, 4'h5, resp);
    eb = exp_b.pop_front(); vectors++;
    if (resp !== eb) begin miscompares++; $display("FAIL strobe_bresp1: got %b want %b", resp, eb); end
    exp_r.push_back({OKAY, 32'hAA22CC44});
    axi_read(5'h0C, data, resp);
    e = exp_r.pop_front(); vectors++;
    if ({resp, data} !== e) begin miscompares++; $display("FAIL strobe_read: got %h want %h", {resp, data}, e); end
  endtask

  // AW-before-W and W-before-AW with BREADY stalled for four cycles
  task automatic test_split();
    logic [1:0] resp;
    logic [31:0] data, val;
    logic [33:0] e;
    logic [4:0] got5;
    logic aw_first;
    bit hs;
    int gap, n;
    for (int c = 0; c < 2; c++) begin
      aw_first = (c == 0);
      gap = (c == 0) ? 3 : 2;
      val = 32'h5A5A0001 + 32'(c);
      awaddr = 5'h0C; wdata = val; wstrb = 4'hF; bready = 1'b0;
      if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 20) begin hs = aw_first ? awready : wready; tick(); n++; end
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (gap - 1) tick();
      vectors++;
      if (bvalid !== 1'b0) begin miscompares++; $display("FAIL split_early_bvalid[%0d]: got %b want 0", c, bvalid); end
      if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
      hs = 1'b0;
      while (!hs && n < 40) begin hs = aw_first ? wready : awready; tick(); n++; end
      awvalid = 1'b0; wvalid = 1'b0;
      vectors++;
      if (!hs) begin miscompares++; $display("FAIL split_handshake[%0d]: got 0 want 1", c); end
      exp_b.push_back(OKAY);
      tick();
      for (int k = 0; k < 4; k++) begin
        got5 = {bvalid, bresp, awready, wready};
        vectors++;
        if (got5 !== {1'b1, exp_b[0], 2'b00}) begin
          miscompares++;
          $display("FAIL split_bhold[%0d.%0d]: got %b want %b", c, k, got5, {1'b1, exp_b[0], 2'b00});
        end
        tick();
      end
      void'(exp_b.pop_front());
      bready = 1'b1;
      tick();
      vectors++;
      if (bvalid !== 1'b0) begin miscompares++; $display("FAIL split_bclear[%0d]: got %b want 0", c, bvalid); end
      exp_r.push_back({OKAY, val});
      axi_read(5'h0C, data, resp);
      e = exp_r.pop_front(); vectors++;
      if ({resp, data} !== e) begin miscompares++; $display("FAIL split_read[%0d]: got %h want %h", c, {resp, data}, e); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] w;
    logic [1:0] resp;
    logic [31:0] data;
    logic [33:0] e;
    wr(5'h00, 32'h0); wr(5'h04, 32'd3); wr(5'h08, 32'h5);
    repeat (3) tick();
    // Normal polarity: led_state toggles every 3 cycles, led lags by one
    wr(5'h00, 32'h1);
    for (int k = 1; k <= 18; k++) begin
      exp_led.push_back(((((k - 1) / 3) % 2) != 0) ? 4'h5 : 4'h0);
      tick();
      w = exp_led.pop_front(); vectors++;
      if (led !== w) begin miscompares++; $display("FAIL blink_norm[%0d]: got %h want %h", k, led, w); end
    end
    wr(5'h00, 32'h0);
    repeat (3) tick();
    // Inverted polarity
    wr(5'h00, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      exp_led.push_back(((((k - 1) / 3) % 2) == 0) ? 4'h5 : 4'h0);
      tick();
      w = exp_led.pop_front(); vectors++;
      if (led !== w) begin miscompares++; $display("FAIL blink_inv[%0d]: got %h want %h", k, led, w); end
    end
    // Disable: led reaches 0 two cycles after the update and stays there
    wr(5'h00, 32'h0);
    tick();
    for (int k = 2; k <= 5; k++) begin
      exp_led.push_back(4'h0);
      tick();
      w = exp_led.pop_front(); vectors++;
      if (led !== w) begin miscompares++; $display("FAIL blink_off[%0d]: got %h want %h", k, led, w); end
    end
    // HALF_PERIOD=1 toggles every cycle
    wr(5'h04, 32'd1);
    repeat (2) tick();
    wr(5'h00, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      exp_led.push_back((((k - 1) % 2) != 0) ? 4'h5 : 4'h0);
      tick();
      w = exp_led.pop_front(); vectors++;
      if (led !== w) begin miscompares++; $display("FAIL blink_hp1[%0d]: got %h want %h", k, led, w); end
    end
    // STATUS exposes the running counter
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h100);
    wr(5'h00, 32'h1);
    repeat (10) tick();
    exp_r.push_back({OKAY, 32'h00000A00});
    axi_read(5'h10, data, resp);
    e = exp_r.pop_front(); vectors++;
    if ({resp, data} !== e) begin miscompares++; $display("FAIL status_cnt: got %h want %h", {resp, data}, e); end
    wr(5'h00, 32'h0);
  endtask

  task automatic test_slverr();
    logic [1:0] resp, eb;
    logic [31:0] data;
    logic [33:0] e;
    logic [4:0] waddrs [3];
    logic [4:0] raddrs [7];
    logic [33:0] rexp [7];
    waddrs[0] = 5'h10; waddrs[1] = 5'h18; waddrs[2] = 5'h1C;
    for (int i = 0; i < 3; i++) begin
      exp_b.push_back(SLVERR);
      axi_write(waddrs[i], 32'hFFFFFFFF, 4'hF, resp);
      eb = exp_b.pop_front(); vectors++;
      if (resp !== eb) begin miscompares++; $display("FAIL slverr_bresp[%h]: got %b want %b", waddrs[i], resp, eb); end
    end
    raddrs[0] = 5'h18; rexp[0] = {SLVERR, 32'h0};
    raddrs[1] = 5'h1C; rexp[1] = {SLVERR, 32'h0};
    raddrs[2] = 5'h0C; rexp[2] = {OKAY, 32'h5A5A0002};
    raddrs[3] = 5'h0F; rexp[3] = {OKAY, 32'h5A5A0002};
    raddrs[4] = 5'h10; rexp[4] = {OKAY, 32'h0};
    raddrs[5] = 5'h08; rexp[5] = {OKAY, 32'h5};
`ifdef BLINK_IRQ_EN
    raddrs[6] = 5'h04; rexp[6] = {OKAY, 32'h100};
`else
    raddrs[6] = 5'h14; rexp[6] = {SLVERR, 32'h0};
`endif
    for (int i = 0; i < 7; i++) begin
      exp_r.push_back(rexp[i]);
      axi_read(raddrs[i], data, resp);
      e = exp_r.pop_front(); vectors++;
      if ({resp, data} !== e) begin miscompares++; $display("FAIL slverr_read[%h]: got %h want %h", raddrs[i], {resp, data}, e); end
    end
  endtask

`ifdef BLINK_IRQ_EN
  task automatic test_irq();
    logic [1:0] resp;
    logic [31:0] data;
    logic [33:0] e;
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b want 0", irq); end
    wr(5'h04, 32'd2);
    wr(5'h14, 32'h1);
    wr(5'h00, 32'h5);
    repeat (8) tick();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b want 1", irq); end
    wr(5'h00, 32'h4);
    repeat (4) tick();
    exp_r.push_back({OKAY, 32'h1});
    axi_read(5'h14, data, resp);
    e = exp_r.pop_front(); vectors++;
    if ({resp, data} !== e) begin miscompares++; $display("FAIL irq_status_read: got %h want %h", {resp, data}, e); end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_sticky: got %b want 1", irq); end
    exp_b.push_back(OKAY);
    axi_write(5'h14, 32'h1, 4'h1, resp);
    vectors++;
    if (resp !== exp_b[0]) begin miscompares++; $display("FAIL irq_w1c_bresp: got %b want %b", resp, exp_b[0]); end
    void'(exp_b.pop_front());
    repeat (2) tick();
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", irq); end
    exp_r.push_back({OKAY, 32'h0});
    axi_read(5'h14, data, resp);
    e = exp_r.pop_front(); vectors++;
    if ({resp, data} !== e) begin miscompares++; $display("FAIL irq_status_clr: got %h want %h", {resp, data}, e); end
    wr(5'h00, 32'h0);
  endtask
`endif

  task automatic test_reset_midflight();
    logic [1:0] resp;
    logic [31:0] data;
    logic [33:0] e;
    wr(5'h04, 32'd100);
    wr(5'h00, 32'h3);
    repeat (3) tick();
    vectors++;
    if (led !== 4'h5) begin miscompares++; $display("FAIL mid_led_before: got %h want 5", led); end
    rready = 1'b0;
    axi_read(5'h0C, data, resp);
    vectors++;
    if (rvalid !== 1'b1) begin miscompares++; $display("FAIL mid_rvalid_pending: got %b want 1", rvalid); end
    rst = 1'b1;
    tick();
    vectors++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'd0) begin
      miscompares++;
      $display("FAIL mid_reset_hs: got %b want 0", {rvalid, bvalid, arready, awready, wready});
    end
    vectors++;
    if (led !== 4'h0) begin miscompares++; $display("FAIL mid_reset_led: got %h want 0", led); end
    rst = 1'b0; rready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
`ifndef BLINK_IRQ_EN
      if (i == 5) break;
`endif
      exp_r.push_back({OKAY, 32'h0});
      axi_read(5'(i * 4), data, resp);
      e = exp_r.pop_front(); vectors++;
      if ({resp, data} !== e) begin miscompares++; $display("FAIL mid_read[%0d]: got %h want %h", i, {resp, data}, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    wdata = '0; wstrb = '0;
    test_reset();
    test_regs();
    test_strobe();
    test_split();
    test_blink();
    test_slverr();
`ifdef BLINK_IRQ_EN
    test_irq();
`endif
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
